// File: rtl/key_input_decoder_pkg.sv
// Shared codes for the piano input front end: note numbers, octave encodings,
// button indices and the per-bit debounce state type.
package key_input_decoder_pkg;

  localparam logic [3:0] NOTE_NONE = 4'd0;
  localparam logic [3:0] NOTE_DO   = 4'd1;
  localparam logic [3:0] NOTE_RE   = 4'd2;
  localparam logic [3:0] NOTE_MI   = 4'd3;
  localparam logic [3:0] NOTE_FA   = 4'd4;
  localparam logic [3:0] NOTE_SOL  = 4'd5;
  localparam logic [3:0] NOTE_LA   = 4'd6;
  localparam logic [3:0] NOTE_SI   = 4'd7;

  localparam logic [1:0] OCT_MID  = 2'b00;
  localparam logic [1:0] OCT_LOW  = 2'b01;
  localparam logic [1:0] OCT_HIGH = 2'b10;

  localparam int BTN_PREV  = 0;
  localparam int BTN_PAUSE = 1;
  localparam int BTN_NEXT  = 2;

  typedef enum logic {
    ST_STABLE,
    ST_COUNTING
  } db_state_e;

  // key[6] is do (code 1) down to key[0] si (code 7); scanning upward lets the
  // highest pressed index overwrite lower ones.
  function automatic logic [3:0] encode_note(input logic [6:0] k);
    logic [3:0] code;
    code = NOTE_NONE;
    for (int i = 0; i < 7; i++) begin
      if (k[i]) code = 4'(7 - i);
    end
    return code;
  endfunction

  function automatic logic [1:0] decode_octave(input logic [1:0] p);
    logic [1:0] oct;
    case (p)
      2'b01:   oct = OCT_LOW;
      2'b10:   oct = OCT_HIGH;
      default: oct = OCT_MID;
    endcase
    return oct;
  endfunction

endpackage

// File: rtl/key_input_decoder_if.sv
// Board-side inputs and conditioned outputs of the piano input decoder.
interface key_input_decoder_if;
  logic [6:0] key;
  logic [2:0] button;
  logic [1:0] pitch;
  logic [3:0] note_code;
  logic [1:0] octave;
  logic       note_start;
  logic       note_end;
  logic [2:0] btn_level;
  logic [2:0] btn_pulse;

  modport master (
    output key, button, pitch,
    input  note_code, octave, note_start, note_end, btn_level, btn_pulse
  );

  modport slave (
    input  key, button, pitch,
    output note_code, octave, note_start, note_end, btn_level, btn_pulse
  );
endinterface

// File: rtl/key_input_decoder_debounce_cell.sv
// One-bit conditioner: 2-FF synchroniser followed by a counter that accepts a
// level change only after DB_CYCLES consecutive differing samples.
module debounce_cell
  import key_input_decoder_pkg::*;
#(
  parameter int DB_CYCLES = 2_000_000,
  parameter int CNT_W     = 21
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic dout
);

  logic             sync_p0, sync_p1;
  db_state_e        state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic             level, level_n;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_p0 <= 1'b0;
      sync_p1 <= 1'b0;
      state   <= ST_STABLE;
      cnt     <= '0;
      level   <= 1'b0;
    end else begin
      sync_p0 <= din;
      sync_p1 <= sync_p0;
      state   <= state_n;
      cnt     <= cnt_n;
      level   <= level_n;
    end
  end

  // The first differing sample counts as 1, so the toggle lands on the
  // DB_CYCLES-th consecutive differing sample.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    level_n = level;
    case (state)
      ST_STABLE: begin
        cnt_n = '0;
        if (sync_p1 != level) begin
          state_n = ST_COUNTING;
          cnt_n   = CNT_W'(1);
        end
      end
      ST_COUNTING: begin
        if (sync_p1 == level) begin
          state_n = ST_STABLE;
          cnt_n   = '0;
        end else if (cnt == CNT_W'(DB_CYCLES - 1)) begin
          state_n = ST_STABLE;
          cnt_n   = '0;
          level_n = ~level;
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      default: begin
        state_n = ST_STABLE;
        cnt_n   = '0;
      end
    endcase
  end

  assign dout = level;

endmodule

// File: rtl/key_input_decoder.sv
// Piano input front end: debounces keys, buttons and octave switches, then
// registers the encoded note, octave and press/release pulses.
module key_input_decoder
  import key_input_decoder_pkg::*;
#(
  parameter int DB_CYCLES = 2_000_000,
  parameter int CNT_W     = 21
) (
  input logic                 clk,
  input logic                 rst,
  key_input_decoder_if.slave  bus
);

  logic [11:0] raw, db;
  logic [6:0]  key_db;
  logic [2:0]  btn_db;
  logic [1:0]  pitch_db;

  assign raw = {bus.pitch, bus.button, bus.key};

  for (genvar g = 0; g < 12; g++) begin : g_db
    debounce_cell #(
      .DB_CYCLES(DB_CYCLES),
      .CNT_W    (CNT_W)
    ) u_cell (
      .clk (clk),
      .rst (rst),
      .din (raw[g]),
      .dout(db[g])
    );
  end

  assign key_db   = db[6:0];
  assign btn_db   = db[9:7];
  assign pitch_db = db[11:10];

  // Stage p0: combinational encode of the debounced levels
  logic [3:0] note_p0;
  logic [1:0] oct_p0;

  assign note_p0 = encode_note(key_db);
  assign oct_p0  = decode_octave(pitch_db);

  // Stage p1: registered outputs; pulses compare next note against current
  logic [3:0] note_p1;
  logic [1:0] oct_p1;
  logic       start_p1, end_p1;
  logic [2:0] btn_prev_p1, btn_pulse_p1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      note_p1      <= NOTE_NONE;
      oct_p1       <= OCT_MID;
      start_p1     <= 1'b0;
      end_p1       <= 1'b0;
      btn_prev_p1  <= '0;
      btn_pulse_p1 <= '0;
    end else begin
      note_p1      <= note_p0;
      oct_p1       <= oct_p0;
      start_p1     <= (note_p0 != NOTE_NONE) && (note_p0 != note_p1);
      end_p1       <= (note_p0 == NOTE_NONE) && (note_p1 != NOTE_NONE);
      btn_prev_p1  <= btn_db;
      btn_pulse_p1 <= btn_db & ~btn_prev_p1;
    end
  end

  assign bus.note_code  = note_p1;
  assign bus.octave     = oct_p1;
  assign bus.note_start = start_p1;
  assign bus.note_end   = end_p1;
  assign bus.btn_level  = {btn_db[BTN_NEXT], btn_db[BTN_PAUSE], btn_db[BTN_PREV]};
  assign bus.btn_pulse  = btn_pulse_p1;

endmodule

// File: tb/tb_key_input_decoder.sv
// Bench for key_input_decoder at DB_CYCLES=4: directed sequences, a constant
// vector table and random stimulus against a run-length reference model.
module tb_key_input_decoder;

  localparam int DB = 4;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_err;

  key_input_decoder_if bus ();

  key_input_decoder #(.DB_CYCLES(DB), .CNT_W(3)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state
  logic [11:0] m_h0, m_h1, m_lvl;
  int          m_run [12];
  logic [3:0]  m_note;
  logic [1:0]  m_oct;
  logic        m_start, m_end;
  logic [2:0]  m_bprev, m_bpulse;

  task automatic model_reset();
    m_h0 = '0; m_h1 = '0; m_lvl = '0;
    for (int b = 0; b < 12; b++) m_run[b] = 0;
    m_note = '0; m_oct = '0; m_start = 1'b0; m_end = 1'b0;
    m_bprev = '0; m_bpulse = '0;
  endtask

  task automatic model_step();
    logic [11:0] raw;
    logic [3:0]  nn;
    raw = {bus.pitch, bus.button, bus.key};
    nn = 4'd0;
    for (int i = 6; i >= 0; i--) begin
      if (m_lvl[i]) begin
        nn = 4'(7 - i);
        break;
      end
    end
    m_start = (nn != 0) && (nn != m_note);
    m_end   = (nn == 0) && (m_note != 0);
    m_note  = nn;
    m_oct   = (m_lvl[11:10] == 2'b01) ? 2'b01 : (m_lvl[11:10] == 2'b10) ? 2'b10 : 2'b00;
    m_bpulse = m_lvl[9:7] & ~m_bprev;
    m_bprev  = m_lvl[9:7];
    // A bit is accepted once the synced value has differed for DB samples in a row.
    for (int b = 0; b < 12; b++) begin
      if (m_h1[b] == m_lvl[b]) m_run[b] = 0;
      else begin
        m_run[b]++;
        if (m_run[b] == DB) begin
          m_lvl[b] = ~m_lvl[b];
          m_run[b] = 0;
        end
      end
    end
    m_h1 = m_h0;
    m_h0 = raw;
  endtask

  function automatic logic [13:0] dut_vec();
    return {bus.note_code, bus.octave, bus.note_start, bus.note_end, bus.btn_level, bus.btn_pulse};
  endfunction

  function automatic logic [13:0] model_vec();
    return {m_note, m_oct, m_start, m_end, m_lvl[9:7], m_bpulse};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst) model_reset();
    else model_step();
    @(negedge clk);
    chk("model", 32'(dut_vec()), 32'(model_vec()));
  endtask

  task automatic drive(input logic [6:0] k, input logic [2:0] b, input logic [1:0] p);
    bus.key = k; bus.button = b; bus.pitch = p;
  endtask

  task automatic settle();
    for (int i = 0; i < 12; i++) tick();
  endtask

  typedef struct {
    logic [6:0] key;
    logic [2:0] btn;
    logic [1:0] pitch;
    logic [3:0] note;
    logic [1:0] oct;
  } vec_t;

  vec_t vecs [7];

  int starts, ends;

  initial begin
    n_cmp = 0;
    n_err = 0;
    vecs[0] = '{7'b0100000, 3'b000, 2'b01, 4'd2, 2'b01};
    vecs[1] = '{7'b0000001, 3'b001, 2'b10, 4'd7, 2'b10};
    vecs[2] = '{7'b1111111, 3'b100, 2'b11, 4'd1, 2'b00};
    vecs[3] = '{7'b0011000, 3'b000, 2'b00, 4'd3, 2'b00};
    vecs[4] = '{7'b0000110, 3'b010, 2'b01, 4'd5, 2'b01};
    vecs[5] = '{7'b0001001, 3'b111, 2'b10, 4'd4, 2'b10};
    vecs[6] = '{7'b0000000, 3'b000, 2'b00, 4'd0, 2'b00};

    rst = 1'b1;
    drive('0, '0, '0);
    model_reset();
    tick(); tick();
    rst = 1'b0;

    // 1: idle after reset
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("idle_zero", 32'(dut_vec()), 32'd0);
    end

    // 2: key[4] press and release, exact latency
    drive(7'b0010000, '0, '0);
    for (int i = 1; i <= 8; i++) begin
      tick();
      if (i == 7) begin
        chk("press_note", 32'(bus.note_code), 32'd3);
        chk("press_start", 32'(bus.note_start), 32'd1);
      end else chk("press_start_idle", 32'(bus.note_start), 32'd0);
    end
    drive('0, '0, '0);
    for (int i = 1; i <= 8; i++) begin
      tick();
      if (i == 7) begin
        chk("release_note", 32'(bus.note_code), 32'd0);
        chk("release_end", 32'(bus.note_end), 32'd1);
      end else chk("release_end_idle", 32'(bus.note_end), 32'd0);
    end
    settle();

    // 3: 3-cycle glitch on key[2] is rejected
    drive(7'b0000100, '0, '0);
    tick(); tick(); tick();
    drive('0, '0, '0);
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("glitch", 32'({bus.note_code, bus.note_start, bus.note_end}), 32'd0);
    end

    // 4: la held, then re added -> 6 to 2, one start, no end
    drive(7'b0000010, '0, '0);
    settle();
    chk("la_held", 32'(bus.note_code), 32'd6);
    drive(7'b0100010, '0, '0);
    starts = 0; ends = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      starts += int'(bus.note_start);
      ends   += int'(bus.note_end);
    end
    chk("re_over_la", 32'(bus.note_code), 32'd2);
    chk("change_starts", 32'(starts), 32'd1);
    chk("change_ends", 32'(ends), 32'd0);
    drive('0, '0, '0);
    settle();

    // 5: simultaneous prev+next buttons
    drive('0, 3'b101, '0);
    for (int i = 1; i <= 8; i++) begin
      tick();
      if (i == 7) chk("btn_pulse", 32'(bus.btn_pulse), 32'b101);
      else chk("btn_pulse_idle", 32'(bus.btn_pulse), 32'd0);
      if (i >= 7) chk("btn_level", 32'(bus.btn_level), 32'b101);
    end
    drive('0, '0, '0);
    settle();

    // 6: high octave with do, async reset mid-hold, then re-acquire
    drive(7'b1000000, '0, 2'b10);
    settle();
    chk("do_note", 32'(bus.note_code), 32'd1);
    chk("do_octave", 32'(bus.octave), 32'b10);
    #2 rst = 1'b1;
    #1 chk("async_reset", 32'(dut_vec()), 32'd0);
    model_reset();
    tick();
    rst = 1'b0;
    for (int i = 1; i <= 7; i++) begin
      tick();
      if (i == 7) chk("restart_start", 32'(bus.note_start), 32'd1);
      else chk("restart_idle", 32'(bus.note_start), 32'd0);
    end
    settle();

    // Vector table: steady-state results
    for (int v = 0; v < 7; v++) begin
      drive(vecs[v].key, vecs[v].btn, vecs[v].pitch);
      settle();
      chk("tbl_note", 32'(bus.note_code), 32'(vecs[v].note));
      chk("tbl_octave", 32'(bus.octave), 32'(vecs[v].oct));
      chk("tbl_btn", 32'(bus.btn_level), 32'(vecs[v].btn));
    end

    // Random toggling: mixes glitches with long holds
    for (int c = 0; c < 600; c++) begin
      logic [11:0] r;
      r = {bus.pitch, bus.button, bus.key};
      for (int b = 0; b < 12; b++) if ($urandom_range(0, 5) == 0) r[b] = ~r[b];
      drive(r[6:0], r[9:7], r[11:10]);
      if (c == 300) rst = 1'b1;
      if (c == 302) rst = 1'b0;
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
